// File: rtl/spi_gen_pkg.sv
// Shared types for the generic SPI slave: FSM state encoding and {CPOL,CPHA} mode codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package spi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        XFER   = 2'd2
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings one asynchronous SPI pin into CLK and flags its rising/falling edges.
// Latency: edges flagged STAGES-1 CLKs after capture; lvl lags one CLK further.
// Backpressure: none, free-running.
module spi_pin_sync #(
    parameter int STAGES = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    // Reset to 0 so a CSEL held low across reset never looks like a fresh fall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_gen.sv
// Full-duplex SPI slave, all four modes, 1..MAX_BYTES byte frames, abort on early CSEL release.
// Latency: 2-3 CLK pin sync, MISO one CLK after the edge; rx_valid/rx_abort one CLK after the event.
// Backpressure: tx_load accepted only while tx_ready; rx outputs are pulses with no stall.
module spi_slave_gen
    import spi_gen_pkg::*;
#(
    parameter int MAX_BYTES   = 6,
    parameter int LEN_W       = $clog2(MAX_BYTES + 1),
    parameter int SYNC_STAGES = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SCK,
    input  logic                   MOSI,
    input  logic                   CSEL,
    output logic                   MISO,
    input  logic [1:0]             mode,
    input  logic [LEN_W-1:0]       frame_bytes,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_ready,
    output logic                   busy,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic [LEN_W-1:0]       rx_bytes,
    output logic                   rx_valid,
    output logic                   rx_abort
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int BW = $clog2(DW + 1);

    logic sck_rise, sck_fall, unused_sck_lvl;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;
    logic csel_lvl, csel_rise, csel_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .CLK(CLK), .RST(RST), .pin(SCK),
        .lvl(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .CLK(CLK), .RST(RST), .pin(MOSI),
        .lvl(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_csel (
        .CLK(CLK), .RST(RST), .pin(CSEL),
        .lvl(csel_lvl), .rise(csel_rise), .fall(csel_fall)
    );

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [DW-1:0]    tx_buf_q, tx_sh_q, rx_sh_q, rx_data_q;
    logic [LEN_W-1:0] rx_bytes_q;
    logic             miso_q, rx_valid_q, rx_abort_q;

    logic             start, cpha_q, lead, trail, do_sample, do_shift, last, abort;
    logic [LEN_W-1:0] start_len;
    logic [BW-1:0]    start_nbits, nbits, received;
    logic [DW-1:0]    tx_src, tx_align;

    always_comb begin
        start       = csel_fall && (state_q != XFER);
        start_len   = (frame_bytes == '0 || frame_bytes > LEN_W'(MAX_BYTES))
                      ? LEN_W'(MAX_BYTES) : frame_bytes;
        start_nbits = BW'({start_len, 3'b000});
        // The buffer is always zero in IDLE, so an unloaded frame sends zeros.
        tx_src      = (state_q == IDLE && tx_load) ? tx_data : tx_buf_q;
        tx_align    = tx_src << ((MAX_BYTES - int'(start_len)) * 8);
        nbits       = BW'({len_q, 3'b000});
        received    = nbits - BW'(1) - bit_cnt_q;
        cpha_q      = (mode_q == MODE1) || (mode_q == MODE3);
        lead        = (mode_q == MODE0 || mode_q == MODE1) ? sck_rise : sck_fall;
        trail       = (mode_q == MODE0 || mode_q == MODE1) ? sck_fall : sck_rise;
        do_sample   = (state_q == XFER) && (cpha_q ? trail : lead);
        do_shift    = (state_q == XFER) && (cpha_q ? lead : trail);
        last        = do_sample && (bit_cnt_q == '0);
        abort       = (state_q == XFER) && csel_rise;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = XFER; else if (tx_load) state_d = LOADED;
            LOADED:  if (start) state_d = XFER;
            XFER:    if (abort || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q     <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            tx_buf_q   <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_bytes_q <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
            if (state_q == IDLE && tx_load && !start) begin
                tx_buf_q <= tx_data;
            end
            if (start) begin
                mode_q    <= mode;
                len_q     <= start_len;
                bit_cnt_q <= start_nbits - BW'(1);
                rx_sh_q   <= '0;
                tx_buf_q  <= '0;
                if (!mode[0]) begin
                    miso_q  <= tx_align[DW-1];
                    tx_sh_q <= tx_align << 1;
                end else begin
                    miso_q  <= 1'b0;
                    tx_sh_q <= tx_align;
                end
            end else if (abort) begin
                // Drop the partial byte: shift out the bits beyond the last byte boundary.
                rx_abort_q <= 1'b1;
                rx_data_q  <= rx_sh_q >> received[2:0];
                rx_bytes_q <= LEN_W'(received >> 3);
                miso_q     <= 1'b0;
            end else begin
                if (do_shift) begin
                    miso_q  <= tx_sh_q[DW-1];
                    tx_sh_q <= tx_sh_q << 1;
                end
                if (do_sample) begin
                    rx_sh_q <= {rx_sh_q[DW-2:0], mosi_lvl};
                    if (last) begin
                        rx_data_q  <= {rx_sh_q[DW-2:0], mosi_lvl};
                        rx_bytes_q <= len_q;
                        rx_valid_q <= 1'b1;
                        miso_q     <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - BW'(1);
                    end
                end
            end
        end
    end

    assign MISO     = miso_q & ~csel_lvl;
    assign busy     = (state_q == XFER);
    assign tx_ready = (state_q == IDLE);
    assign rx_data  = rx_data_q;
    assign rx_bytes = rx_bytes_q;
    assign rx_valid = rx_valid_q;
    assign rx_abort = rx_abort_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Randomised SPI master driving spi_slave_gen; expected rx results are queued per frame
// and a separate monitor checks every rx_valid/rx_abort pulse against the queue.
module tb_spi_slave_gen;

    localparam int MB   = 6;
    localparam int DW   = 8 * MB;
    localparam int LW   = 3;
    localparam int HALF = 60;

    logic          CLK, RST, SCK, MOSI, CSEL, MISO;
    logic [1:0]    mode;
    logic [LW-1:0] frame_bytes;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_load, tx_ready, busy, rx_valid, rx_abort;
    logic [LW-1:0] rx_bytes;

    spi_slave_gen #(.MAX_BYTES(MB), .LEN_W(LW), .SYNC_STAGES(3)) dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .MOSI(MOSI), .CSEL(CSEL), .MISO(MISO),
        .mode(mode), .frame_bytes(frame_bytes), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .busy(busy), .rx_data(rx_data), .rx_bytes(rx_bytes),
        .rx_valid(rx_valid), .rx_abort(rx_abort)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit            abort;
        logic [DW-1:0] data;
        logic [LW-1:0] bytes;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_pulse = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask(input int bits);
        logic [DW-1:0] one;
        one = 1;
        return (bits >= DW) ? '1 : ((one << bits) - 1);
    endfunction

    function automatic logic [DW-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic int eff_bytes(input int fb);
        return (fb == 0 || fb > MB) ? MB : fb;
    endfunction

    function automatic logic bitv(input logic [DW-1:0] w, input int n, input int i);
        return (i < n) ? w[n-1-i] : 1'b0;
    endfunction

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && (rx_valid || rx_abort)) begin
            chk("pulse_width", {63'd0, prev_pulse}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rx", {62'd0, rx_valid, rx_abort}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_kind", {62'd0, rx_valid, rx_abort}, e.abort ? 64'd1 : 64'd2);
                chk("rx_data", {16'd0, rx_data}, {16'd0, e.data});
                chk("rx_bytes", {61'd0, rx_bytes}, {61'd0, e.bytes});
            end
        end
        prev_pulse = rx_valid || rx_abort;
    end

    task automatic spi_xfer(input logic [1:0] m, input int nclk, input int n,
                            input logic [DW-1:0] w, input int rst_at, input bit poke,
                            output logic [DW-1:0] cap);
        logic cpol, cpha;
        cpol = m[1];
        cpha = m[0];
        cap  = '0;
        SCK  = cpol;
        #100;
        CSEL = 1'b0;
        if (!cpha) MOSI = bitv(w, n, 0);
        #100;
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                @(negedge CLK) RST = 1'b1;
                @(negedge CLK);
                @(negedge CLK) RST = 1'b0;
                @(negedge CLK);
                chk("rst_rx_data", {16'd0, rx_data}, 64'd0);
                chk("rst_rx_bytes", {61'd0, rx_bytes}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
                chk("rst_miso", {63'd0, MISO}, 64'd0);
            end
            if (i == n / 2 && rst_at < 0) begin
                @(negedge CLK);
                chk("busy_mid", {63'd0, busy}, 64'd1);
                if (poke) begin
                    tx_data = rnd48();
                    tx_load = 1'b1;
                    @(negedge CLK);
                    chk("tx_ready_busy", {63'd0, tx_ready}, 64'd0);
                    tx_load = 1'b0;
                end
            end
            if (!cpha) begin
                SCK = ~cpol;
                if (i < n) cap = {cap[DW-2:0], MISO};
                #HALF;
                SCK  = cpol;
                MOSI = bitv(w, n, i + 1);
                #HALF;
            end else begin
                SCK  = ~cpol;
                MOSI = bitv(w, n, i);
                #HALF;
                SCK = cpol;
                if (i < n) cap = {cap[DW-2:0], MISO};
                #HALF;
            end
        end
        #HALF;
        CSEL = 1'b1;
        #300;
    endtask

    task automatic run_frame(input logic [1:0] m, input int fb, input bit load,
                             input logic [DW-1:0] txw, input logic [DW-1:0] w,
                             input int nclk, input int rst_at, input bit poke);
        int            eb, n, k, b;
        logic [DW-1:0] wd, cap, exp_tx;
        exp_t          e;
        eb = eff_bytes(fb);
        n  = 8 * eb;
        wd = w & mask(n);
        k  = (nclk < n) ? nclk : n;
        mode        = m;
        frame_bytes = LW'(fb);
        if (load) begin
            @(negedge CLK);
            tx_data = txw;
            tx_load = 1'b1;
            @(negedge CLK);
            tx_load = 1'b0;
            tx_data = rnd48();
            chk("tx_ready_loaded", {63'd0, tx_ready}, 64'd0);
        end
        if (rst_at < 0) begin
            if (nclk >= n) begin
                e.abort = 1'b0;
                e.data  = wd;
                e.bytes = LW'(eb);
            end else begin
                b       = nclk / 8;
                e.abort = 1'b1;
                e.data  = wd >> (n - 8 * b);
                e.bytes = LW'(b);
            end
            exp_q.push_back(e);
        end
        spi_xfer(m, nclk, n, wd, rst_at, poke, cap);
        if (rst_at < 0) begin
            exp_tx = load ? (txw & mask(n)) : '0;
            chk("miso_bits", {16'd0, cap}, {16'd0, exp_tx >> (n - k)});
        end
    endtask

    initial begin
        RST = 1'b1; SCK = 1'b0; MOSI = 1'b0; CSEL = 1'b1;
        mode = 2'b00; frame_bytes = '0; tx_data = '0; tx_load = 1'b0;
        #35;
        chk("reset_miso", {63'd0, MISO}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_tx_ready", {63'd0, tx_ready}, 64'd1);
        chk("reset_rx_valid", {62'd0, rx_valid, rx_abort}, 64'd0);
        chk("reset_rx_bytes", {61'd0, rx_bytes}, 64'd0);
        chk("reset_rx_data", {16'd0, rx_data}, 64'd0);
        @(negedge CLK) RST = 1'b0;
        #100;

        run_frame(2'b00, 2, 1, 48'hA55A, 48'h1234, 16, -1, 0);
        run_frame(2'b11, 6, 1, 48'h0123456789AB, 48'hFEDCBA987654, 48, -1, 0);
        run_frame(2'b01, 6, 1, 48'h0123456789AB, 48'hFEDCBA987654, 48, -1, 0);
        run_frame(2'b10, 0, 1, rnd48(), rnd48(), 48, -1, 0);
        run_frame(2'b00, 3, 1, rnd48(), 48'hC33C55, 13, -1, 0);
        run_frame(2'b00, 2, 0, 48'h0, rnd48(), 16, -1, 1);
        run_frame(2'b00, 2, 0, 48'h0, rnd48(), 16, -1, 0);
        run_frame(2'b00, 2, 1, rnd48(), rnd48(), 16, 5, 0);
        run_frame(2'b00, 2, 1, rnd48(), rnd48(), 16, -1, 0);
        run_frame(2'b01, 1, 1, rnd48(), rnd48(), 11, -1, 0);

        for (int it = 0; it < 12; it++) begin
            logic [1:0] m;
            int         fb, n, nclk;
            bit         ld;
            m  = 2'($urandom_range(0, 3));
            fb = $urandom_range(0, 7);
            ld = 1'($urandom_range(0, 1));
            n  = 8 * eff_bytes(fb);
            if ($urandom_range(0, 9) < 7) nclk = n + $urandom_range(0, 2);
            else                          nclk = $urandom_range(0, n - 1);
            run_frame(m, fb, ld, rnd48(), rnd48(), nclk, -1, 0);
        end

        #200;
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
